// File: rtl/vector_issue_ctrl.sv
// ---------------------------------------------------------------------------
// vector_issue_ctrl
//
// Issue sequencer for the vector lane array. Accepts one vector instruction
// at a time, broadcasts opcode/operands/start to every lane, collects the
// per-lane done pulses, and returns a completion response. The fma opcode
// (4'b1111) runs vlen_p/lanes_p lane passes. Each pass steps the source-1
// register (wrapping modulo els_p) and the write-address offset (by lanes_p).
//
// Ports
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   instr_v_i        instruction valid
//   instr_ready_o    controller idle and able to accept an instruction
//   instr_op_i       opcode
//   instr_vd_i       destination vector register
//   instr_vs1_i      source 1 vector register
//   instr_vs2_i      source 2 vector register
//   instr_scalar_i   scalar operand
//   instr_w_data_i   external write data
//   op_o             opcode broadcast to lanes
//   start_o          one-cycle start pulse to all lanes
//   scalar_o         scalar broadcast
//   w_data_o         external write data broadcast
//   vd_o/vs1_o/vs2_o regfile selects
//   w_addr_offset_o  per-pass write-address offset (fma)
//   lane_done_i      per-lane done pulses
//   resp_v_o         instruction complete
//   resp_ready_i     consumer accepts the response
//   busy_o           controller is not idle
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for an instruction, instr_ready_o high
//   ST_ISSUE  | start_o pulse for the current pass
//   ST_WAIT   | collecting lane done pulses into the sticky mask
//   ST_RESP   | response valid, waiting for resp_ready_i
// ---------------------------------------------------------------------------
module vector_issue_ctrl #(
  parameter int els_p      = 8,
  parameter int vlen_p     = 8,
  parameter int vdw_p      = 8,
  parameter int lanes_p    = 4,
  parameter int op_width_p = 4,
  localparam int reg_w_lp  = (els_p  > 1) ? $clog2(els_p)  : 1,
  localparam int off_w_lp  = (vlen_p > 1) ? $clog2(vlen_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,

  input  logic                  instr_v_i,
  output logic                  instr_ready_o,
  input  logic [op_width_p-1:0] instr_op_i,
  input  logic [reg_w_lp-1:0]   instr_vd_i,
  input  logic [reg_w_lp-1:0]   instr_vs1_i,
  input  logic [reg_w_lp-1:0]   instr_vs2_i,
  input  logic [vdw_p-1:0]      instr_scalar_i,
  input  logic [vdw_p-1:0]      instr_w_data_i,

  output logic [op_width_p-1:0] op_o,
  output logic                  start_o,
  output logic [vdw_p-1:0]      scalar_o,
  output logic [vdw_p-1:0]      w_data_o,
  output logic [reg_w_lp-1:0]   vd_o,
  output logic [reg_w_lp-1:0]   vs1_o,
  output logic [reg_w_lp-1:0]   vs2_o,
  output logic [off_w_lp-1:0]   w_addr_offset_o,
  input  logic [lanes_p-1:0]    lane_done_i,

  output logic                  resp_v_o,
  input  logic                  resp_ready_i,
  output logic                  busy_o
);

  localparam int npass_lp  = vlen_p / lanes_p;
  localparam int pass_w_lp = (npass_lp > 1) ? $clog2(npass_lp) : 1;

  localparam logic [op_width_p-1:0] op_fma_lp    = op_width_p'(4'b1111);
  localparam logic [pass_w_lp-1:0]  last_pass_lp = pass_w_lp'(npass_lp - 1);
  localparam logic [off_w_lp-1:0]   off_step_lp  = off_w_lp'(lanes_p);
  localparam logic [reg_w_lp-1:0]   vs1_max_lp   = reg_w_lp'(els_p - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                r_state;
  logic [op_width_p-1:0] r_op;
  logic [reg_w_lp-1:0]   r_vd;
  logic [reg_w_lp-1:0]   r_vs1;
  logic [reg_w_lp-1:0]   r_vs2;
  logic [vdw_p-1:0]      r_scalar;
  logic [vdw_p-1:0]      r_w_data;
  logic [off_w_lp-1:0]   r_w_off;
  logic [pass_w_lp-1:0]  r_pass;
  logic [lanes_p-1:0]    r_done_mask;
  logic                  r_start;
  logic                  r_resp_v;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_is_fma;
  logic                  w_done_all;
  logic                  w_more_passes;
  logic [reg_w_lp-1:0]   w_vs1_next;

  // Ready is only meaningful once reset has been released.
  assign instr_ready_o = (r_state == ST_IDLE) && reset_n_i;
  assign w_accept      = instr_v_i && instr_ready_o;
  assign w_is_fma      = (r_op == op_fma_lp);

  // This cycle's pulses count toward completion so that the final done is
  // answered one cycle later rather than two.
  assign w_done_all    = &(r_done_mask | lane_done_i);
  assign w_more_passes = w_is_fma && (r_pass != last_pass_lp);

  // Explicit wrap keeps the source step modulo els_p even when els_p is not a
  // power of two.
  assign w_vs1_next    = (r_vs1 == vs1_max_lp) ? '0 : r_vs1 + 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= ST_IDLE;
      r_op        <= '0;
      r_vd        <= '0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_scalar    <= '0;
      r_w_data    <= '0;
      r_w_off     <= '0;
      r_pass      <= '0;
      r_done_mask <= '0;
      r_start     <= 1'b0;
      r_resp_v    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= instr_op_i;
            r_vd        <= instr_vd_i;
            r_vs1       <= instr_vs1_i;
            r_vs2       <= instr_vs2_i;
            r_scalar    <= instr_scalar_i;
            r_w_data    <= instr_w_data_i;
            r_w_off     <= '0;
            r_pass      <= '0;
            r_done_mask <= '0;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end

        // Done pulses coinciding with the start pulse belong to no pass.
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (w_done_all) begin
            r_done_mask <= '0;
            if (w_more_passes) begin
              r_pass  <= r_pass + 1'b1;
              r_vs1   <= w_vs1_next;
              r_w_off <= r_w_off + off_step_lp;
              r_start <= 1'b1;
              r_state <= ST_ISSUE;
            end else begin
              r_resp_v <= 1'b1;
              r_state  <= ST_RESP;
            end
          end else begin
            r_done_mask <= r_done_mask | lane_done_i;
          end
        end

        ST_RESP: begin
          if (resp_ready_i) begin
            r_resp_v <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The lane array reads these combinationally, so they come straight from the
  // hold registers and stay put until the next accept or pass step.
  assign op_o            = r_op;
  assign vd_o            = r_vd;
  assign vs1_o           = r_vs1;
  assign vs2_o           = r_vs2;
  assign scalar_o        = r_scalar;
  assign w_data_o        = r_w_data;
  assign w_addr_offset_o = r_w_off;
  assign start_o         = r_start;
  assign resp_v_o        = r_resp_v;
  assign busy_o          = r_busy;

endmodule

// File: tb/tb_vector_issue_ctrl.sv
module tb_vector_issue_ctrl;

  localparam int ELS   = 8;
  localparam int VLEN  = 8;
  localparam int VDW   = 8;
  localparam int LANES = 4;
  localparam int OPW   = 4;
  localparam int RW    = $clog2(ELS);
  localparam int OW    = $clog2(VLEN);
  localparam int NPASS = VLEN / LANES;

  logic             clk;
  logic             rst_n;
  logic             instr_v;
  logic             instr_ready;
  logic [OPW-1:0]   instr_op;
  logic [RW-1:0]    instr_vd, instr_vs1, instr_vs2;
  logic [VDW-1:0]   instr_scalar, instr_w_data;
  logic [OPW-1:0]   op_o;
  logic             start_o;
  logic [VDW-1:0]   scalar_o, w_data_o;
  logic [RW-1:0]    vd_o, vs1_o, vs2_o;
  logic [OW-1:0]    woff_o;
  logic [LANES-1:0] lane_done;
  logic             resp_v;
  logic             resp_ready;
  logic             busy;

  vector_issue_ctrl #(
    .els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW), .lanes_p(LANES), .op_width_p(OPW)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .instr_v_i(instr_v), .instr_ready_o(instr_ready),
    .instr_op_i(instr_op), .instr_vd_i(instr_vd), .instr_vs1_i(instr_vs1),
    .instr_vs2_i(instr_vs2), .instr_scalar_i(instr_scalar), .instr_w_data_i(instr_w_data),
    .op_o(op_o), .start_o(start_o), .scalar_o(scalar_o), .w_data_o(w_data_o),
    .vd_o(vd_o), .vs1_o(vs1_o), .vs2_o(vs2_o), .w_addr_offset_o(woff_o),
    .lane_done_i(lane_done), .resp_v_o(resp_v), .resp_ready_i(resp_ready), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int op, vd, vs1, vs2, scalar, wdata, off, pass, start_cyc;
  } pass_exp_t;

  typedef struct packed {
    logic [LANES-1:0]      noise;
    logic [LANES-1:0][3:0] d;
  } lane_plan_t;

  pass_exp_t  pass_q[$];
  lane_plan_t plan_q[$];
  int         comp_q[$];
  int         resp_q[$];
  int         rwait_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic lane_plan_t rand_plan();
    lane_plan_t p;
    for (int l = 0; l < LANES; l++) p.d[l] = 4'($urandom_range(1, 7));
    p.noise = LANES'($urandom);
    return p;
  endfunction

  function automatic lane_plan_t plan_of(input int d0, d1, d2, d3, input int nz);
    lane_plan_t p;
    p.d[0] = 4'(d0); p.d[1] = 4'(d1); p.d[2] = 4'(d2); p.d[3] = 4'(d3);
    p.noise = LANES'(nz);
    return p;
  endfunction

  // Reference model: each accepted instruction expands into its lane passes
  // from the architectural rules (pass count, vs1 stepping, offset stepping).
  task automatic issue(input int op, vd, vs1, vs2, sc, wd,
                       input lane_plan_t p0, p1, input int rw);
    int t;
    int np;
    pass_exp_t pe;
    instr_op     = OPW'(op);
    instr_vd     = RW'(vd);
    instr_vs1    = RW'(vs1);
    instr_vs2    = RW'(vs2);
    instr_scalar = VDW'(sc);
    instr_w_data = VDW'(wd);
    instr_v      = 1'b1;
    t = 0;
    while (!instr_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 0, 1);
      instr_v = 1'b0;
      return;
    end
    chk("accept_only_when_no_resp", resp_v, 0);
    np = (op == 15) ? NPASS : 1;
    for (int p = 0; p < np; p++) begin
      pe.op = op; pe.vd = vd; pe.vs2 = vs2; pe.scalar = sc; pe.wdata = wd;
      pe.vs1 = (vs1 + p) % ELS;
      pe.off = (p * LANES) % VLEN;
      pe.pass = p;
      pe.start_cyc = (p == 0) ? cyc + 1 : -1;
      pass_q.push_back(pe);
      plan_q.push_back((p == 0) ? p0 : p1);
    end
    resp_q.push_back(np);
    rwait_q.push_back(rw);
    @(negedge clk);
    instr_v = 1'b0;
  endtask

  // Monitor state
  pass_exp_t cur;
  bit  in_pass = 0, prev_start = 0, prev_resp = 0, hs_pend = 0, resp_active = 0;
  int  starts_seen = 0, rwait_cnt = 0, exp_c = 0;
  // Responder state
  lane_plan_t plan;
  logic [LANES-1:0] ld;
  int  mx = 0;
  bit  seen_resp = 0;

  initial begin
    rst_n = 1'b0; instr_v = 1'b0; instr_op = '0; instr_vd = '0; instr_vs1 = '0;
    instr_vs2 = '0; instr_scalar = '0; instr_w_data = '0; lane_done = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", start_o, 0);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", instr_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_op", op_o, 0);
    chk("idle_vd", vd_o, 0);
    chk("idle_vs1", vs1_o, 0);
    chk("idle_woff", woff_o, 0);
    chk("idle_scalar", scalar_o, 0);

    // Reset in the middle of WAIT with two lanes done.
    instr_op = 4'h0; instr_vd = 3'd3; instr_vs1 = 3'd1; instr_vs2 = 3'd2;
    instr_scalar = 8'hA5; instr_w_data = 8'h3C; instr_v = 1'b1;
    @(negedge clk);
    instr_v = 1'b0;
    chk("rw_start", start_o, 1);
    chk("rw_vd", vd_o, 3);
    chk("rw_scalar", scalar_o, 8'hA5);
    @(negedge clk);
    chk("rw_start_one_cycle", start_o, 0);
    lane_done = 4'b0011;
    @(negedge clk);
    lane_done = '0;
    rst_n = 1'b0;
    #1;
    chk("rw_busy0", busy, 0);
    chk("rw_resp0", resp_v, 0);
    chk("rw_vd0", vd_o, 0);
    chk("rw_vs1_0", vs1_o, 0);
    chk("rw_vs2_0", vs2_o, 0);
    chk("rw_scalar0", scalar_o, 0);
    chk("rw_wdata0", w_data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (resp_v || busy) seen_resp = 1;
    end
    chk("rw_no_resp_after_reset", seen_resp, 0);
    chk("rw_ready_after_reset", instr_ready, 1);

    fork
      // Lane responder: per pass, optional noise on the ISSUE cycle, then each
      // lane pulses done after its planned delay, with random repeats.
      forever begin
        @(negedge clk);
        lane_done = '0;
        if (start_o) begin
          if (plan_q.size() == 0) plan = plan_of(1, 1, 1, 1, 0);
          else plan = plan_q.pop_front();
          lane_done = plan.noise;
          mx = 0;
          for (int l = 0; l < LANES; l++) if (int'(plan.d[l]) > mx) mx = int'(plan.d[l]);
          for (int k = 1; k <= mx; k++) begin
            @(negedge clk);
            for (int l = 0; l < LANES; l++)
              ld[l] = (k == int'(plan.d[l])) || (k > int'(plan.d[l]) && ($urandom_range(0, 1) == 1));
            lane_done = ld;
          end
          comp_q.push_back(cyc);
        end
      end

      // Monitor / scoreboard.
      forever begin
        @(negedge clk);
        if (hs_pend) begin
          chk("resp_clear_after_hs", resp_v, 0);
          chk("ready_after_hs", instr_ready, 1);
          hs_pend = 0;
          resp_ready = 1'b0;
          resp_active = 0;
        end else if (prev_resp && !resp_v) begin
          chk("resp_held_until_hs", resp_v, 1);
        end

        if (start_o) begin
          chk("start_single_pulse", prev_start, 0);
          if (pass_q.size() == 0) begin
            chk("unexpected_start", 1, 0);
          end else begin
            cur = pass_q.pop_front();
            in_pass = 1;
            starts_seen++;
            if (cur.pass == 0) exp_c = cur.start_cyc;
            else exp_c = (comp_q.size() > 0) ? comp_q.pop_front() + 1 : -1;
            chk("start_cycle", cyc, exp_c);
            chk("op", op_o, cur.op);
            chk("vd", vd_o, cur.vd);
            chk("vs1", vs1_o, cur.vs1);
            chk("vs2", vs2_o, cur.vs2);
            chk("scalar", scalar_o, cur.scalar);
            chk("wdata", w_data_o, cur.wdata);
            chk("woff", woff_o, cur.off);
            chk("busy_issue", busy, 1);
            chk("ready_issue", instr_ready, 0);
          end
        end else if (in_pass && busy && !resp_v) begin
          chk("hold_vs1", vs1_o, cur.vs1);
          chk("hold_woff", woff_o, cur.off);
          chk("hold_op", op_o, cur.op);
        end

        if (resp_v && !prev_resp) begin
          in_pass = 0;
          exp_c = (comp_q.size() > 0) ? comp_q.pop_front() + 1 : -1;
          chk("resp_cycle", cyc, exp_c);
          if (resp_q.size() == 0) chk("unexpected_resp", 1, 0);
          else chk("pass_count", starts_seen, resp_q.pop_front());
          starts_seen = 0;
          rwait_cnt = (rwait_q.size() > 0) ? rwait_q.pop_front() : 0;
          resp_active = 1;
        end

        if (resp_v && resp_active && !hs_pend) begin
          chk("ready_in_resp", instr_ready, 0);
          chk("busy_in_resp", busy, 1);
          if (rwait_cnt > 0) begin
            rwait_cnt--;
            resp_ready = 1'b0;
          end else begin
            resp_ready = 1'b1;
            hs_pend = 1;
          end
        end

        prev_start = start_o;
        prev_resp  = resp_v;
      end
    join_none

    // Directed scenarios, then randomized traffic.
    issue(0, 3, 1, 2, 8'h11, 8'h22, plan_of(1, 1, 1, 1, 0), plan_of(1, 1, 1, 1, 0), 0);
    issue(0, 5, 4, 6, 8'h5A, 8'h00, plan_of(2, 5, 3, 7, 15), plan_of(1, 1, 1, 1, 0), 0);
    issue(15, 4, 6, 5, 8'h77, 8'h01, rand_plan(), rand_plan(), 1);
    issue(15, 2, 7, 1, 8'h80, 8'hFF, rand_plan(), rand_plan(), 0);
    issue(3, 1, 2, 3, 8'h42, 8'h24, plan_of(1, 2, 1, 2, 0), plan_of(1, 1, 1, 1, 0), 5);
    issue(9, 6, 0, 7, 8'h10, 8'hEE, rand_plan(), rand_plan(), 2);

    for (int i = 0; i < 60; i++) begin
      int op;
      op = ($urandom_range(0, 9) < 3) ? 15 : int'($urandom_range(0, 15));
      issue(op, int'($urandom_range(0, ELS - 1)), int'($urandom_range(0, ELS - 1)),
            int'($urandom_range(0, ELS - 1)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), rand_plan(), rand_plan(),
            int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    begin
      int t;
      t = 0;
      while ((pass_q.size() != 0 || resp_q.size() != 0 || busy) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) chk("drain_timeout", 1, 0);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
